product_accumulator: RTL and testbench

//   Downstream stage of the 4x4 lookup multiplier. Accepts one unsigned product per

---
 rtl/product_accumulator.sv | 58 +++++
 tb/tb_product_accumulator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN unsigned products per frame and holds the total with a sticky overflow flag.
// Define SATURATE_EN to clamp the total at 2**ACC_W-1 on overflow instead of wrapping.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2;
  logic [1:0] st;
  logic [ACC_W-1:0] acc, nxt_acc;
  logic [CNT_W-1:0] cnt;
  logic ovf, accept, rel, last;
  logic [ACC_W:0] sum;
  assign in_ready  = !clear && st != HOLD;
  assign accept    = in_valid && in_ready;
  assign out_valid = st == HOLD;
  assign rel       = out_valid && out_ready;
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign sum  = {1'b0, acc} + (ACC_W + 1)'(in_prod);
  assign last = st == IDLE ? LEN == 1 : cnt == CNT_W'(LEN - 1);
`ifdef SATURATE_EN
  // Once clamped, acc+x still carries out (or adds zero), so it stays at the ceiling.
  assign nxt_acc = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign nxt_acc = sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear || rel) begin
      st  <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      st  <= last ? HOLD : ACCUM;
      acc <= st == IDLE ? ACC_W'(in_prod) : nxt_acc;
      cnt <= st == IDLE ? CNT_W'(1) : cnt + CNT_W'(1);
      ovf <= st == IDLE ? 1'b0 : ovf | sum[ACC_W];
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed frames on a 16-bit and an 8-bit accumulator (LEN=4) against a frame-total model.
module tb_product_accumulator;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_prod = 0;
  logic [1:0] rdy, ov, of;
  logic [15:0] s16;
  logic [7:0] s8;
  int n_cmp = 0, n_bad = 0;
`ifdef SATURATE_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif
  longint tot [2], esum [2];
  int cnt [2];
  bit pend [2], eovf [2];

  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) d16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_prod(in_prod), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s16), .out_ovf(of[0]));
  product_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(4)) d8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_prod(in_prod), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s8), .out_ovf(of[1]));

  always #5 clk = ~clk;

  task automatic chk(input string n, input longint a, input longint e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", n, a, e, $time);
    end
  endtask

  // Frame-level model: a frame is LEN accepted beats; its result is the plain integer total reduced to the output width.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int w = k ? 8 : 16;
      automatic longint mx = (64'd1 << w) - 1;
      automatic longint act = k ? longint'(s8) : longint'(s16);
      if (rst) begin
        tot[k] = 0; cnt[k] = 0; pend[k] = 0;
      end else begin
        chk($sformatf("in_ready[%0d]", k), rdy[k], !clear && !pend[k]);
        chk($sformatf("out_valid[%0d]", k), ov[k], pend[k]);
        if (pend[k] && ov[k]) begin
          chk($sformatf("out_sum[%0d]", k), act, esum[k]);
          chk($sformatf("out_ovf[%0d]", k), of[k], eovf[k]);
        end
        if (clear) begin
          tot[k] = 0; cnt[k] = 0; pend[k] = 0;
        end else if (pend[k]) begin
          if (out_ready) pend[k] = 0;
        end else if (in_valid) begin
          tot[k] += in_prod;
          cnt[k]++;
          if (cnt[k] == 4) begin
            eovf[k] = tot[k] > mx;
            esum[k] = SAT ? (tot[k] > mx ? mx : tot[k]) : tot[k] % (mx + 1);
            pend[k] = 1; tot[k] = 0; cnt[k] = 0;
          end
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) nxt();
  endtask

  task automatic beat(input logic [7:0] p);
    bit ok = 0;
    in_valid = 1; in_prod = p;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = rdy[0];
      nxt();
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    in_valid = 0; in_prod = 'x;
  endtask

  task automatic frame(input logic [7:0] a, b, c, d);
    beat(a); beat(b); beat(c); beat(d);
  endtask

  initial begin
    idle(1); @(posedge clk); #1 rst = 0;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_sum", s16, 0);
    chk("rst_out_ovf", of[0], 0);
    @(negedge clk); chk("rst_in_ready", rdy[0], 1); nxt();
    // single-cycle result with out_ready held high
    frame(3, 5, 7, 9);
    @(negedge clk); chk("t1_valid", ov[0], 1); chk("t1_sum", s16, 24); chk("t1_ovf", of[0], 0); nxt();
    @(negedge clk); chk("t1_one_cycle", ov[0], 0); nxt();
    // result held under backpressure
    out_ready = 0;
    frame(3, 5, 7, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t2_hold_valid", ov[0], 1); chk("t2_hold_sum", s16, 24); chk("t2_hold_ready", rdy[0], 0); nxt();
    end
    out_ready = 1;
    @(negedge clk); chk("t2_still_valid", ov[0], 1); nxt();
    @(negedge clk); chk("t2_idle_valid", ov[0], 0); chk("t2_clean_sum", s16, 0); chk("t2_idle_ready", rdy[0], 1); nxt();
    // gaps between beats
    beat(10); beat(20); idle(3); beat(30); idle(1); beat(40);
    @(negedge clk); chk("t3_sum", s16, 100); chk("t3_valid", ov[0], 1); nxt();
    idle(2);
    // overflow on the 8-bit instance
    frame(225, 225, 225, 225);
    @(negedge clk);
    chk("t4_sum8", s8, SAT ? 255 : 132); chk("t4_ovf8", of[1], 1);
    chk("t4_sum16", s16, 900); chk("t4_ovf16", of[0], 0);
    nxt();
    // clear aborts a partial frame and rejects the coincident beat
    beat(50); beat(60);
    clear = 1; in_valid = 1; in_prod = 70; nxt();
    clear = 0; in_valid = 0;
    @(negedge clk); chk("t5_cleared_sum", s16, 0); nxt();
    frame(1, 2, 3, 4);
    @(negedge clk); chk("t5_sum", s16, 10); chk("t5_ovf", of[0], 0); chk("t5_sum8", s8, 10); nxt();
    // async reset during HOLD
    out_ready = 0;
    frame(3, 5, 7, 9);
    @(negedge clk); chk("t6_pre_sum", s16, 24);
    #1 rst = 1;
    #1 chk("t6_async_valid", ov[0], 0); chk("t6_async_sum", s16, 0); chk("t6_async_valid8", ov[1], 0);
    @(negedge clk); nxt(); rst = 0; out_ready = 1;
    frame(1, 1, 1, 1);
    @(negedge clk); chk("t6_sum", s16, 4); chk("t6_valid", ov[0], 1); nxt();
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
